// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the loadable instruction memory.
//   state_e      - controller states (clear fill, normal fetch, boot load)
//   MIPS_NOP     - canonical MIPS no-op (sll $0,$0,0), default fill/fault word
//   fetch_fault  - classifies a byte fetch address as illegal for a given
//                  index width and depth
package imem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Misaligned, past the last word, or any bit set above the index field.
    function automatic logic fetch_fault(input logic [31:0] addr,
                                         input int unsigned addr_w,
                                         input int unsigned depth);
        logic [31:0] widx;
        logic [31:0] hi;
        widx = addr >> 2;
        hi   = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (widx >= depth) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram: simple dual-address synchronous RAM, one write port and one
// registered read port. The controller guarantees writes and reads never
// occur in the same cycle.
//   clk            - clock
//   we/waddr/wdata - write strobe, word index, data
//   re/raddr       - read strobe, word index; rdata updates only when re=1
//   rdata          - registered read data (holds between reads)
module imem_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned WIDTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q    <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory for the pipelined MIPS
// core, between the IF-stage PC register and the IF/ID register.
// After reset the array is filled with NOP_WORD (DEPTH cycles), then fetches
// return the word at fetch_addr one cycle later. A load_start pulse enters a
// word-serial boot load; the load ends on load_last or on the final entry.
// Optional build macro IMEM_PARITY_EN: stores an even-parity bit per entry
// and adds the parity_err output.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   load_start                  - enter LOAD from RUN
//   load_valid/load_data/load_last - load word stream
//   load_ready, load_done       - in LOAD / one-cycle LOAD->RUN pulse
//   fetch_addr, stall           - byte PC, hold current output
//   instr, instr_valid, addr_fault - fetch result (parity_err if enabled)
module imem_loadable
    import imem_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 256,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic [31:0]       fetch_addr,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
`ifdef IMEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              addr_fault
);

`ifdef IMEM_PARITY_EN
    localparam int unsigned RAM_W = DATA_W + 1;
    function automatic logic [RAM_W-1:0] enc_word(input logic [DATA_W-1:0] d);
        return {^d, d};
    endfunction
`else
    localparam int unsigned RAM_W = DATA_W;
    function automatic logic [RAM_W-1:0] enc_word(input logic [DATA_W-1:0] d);
        return d;
    endfunction
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              sel_q, sel_d;     // output comes from the RAM, not NOP
    logic              done_q, done_d;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [RAM_W-1:0]  ram_wdata, ram_rdata;
    logic              fault_now, rd_ok;

    assign fault_now = fetch_fault(fetch_addr, ADDR_W, DEPTH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        sel_d     = sel_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = cnt_q;
        ram_wdata = enc_word(NOP_WORD);
        case (state_q)
            ST_CLEAR: begin
                ram_we  = 1'b1;
                valid_d = 1'b0;
                fault_d = 1'b0;
                sel_d   = 1'b0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    sel_d   = 1'b0;
                end else if (!stall) begin
                    valid_d = 1'b1;
                    fault_d = fault_now;
                    sel_d   = !fault_now;
                    ram_re  = !fault_now;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    ram_we    = 1'b1;
                    ram_waddr = ptr_q;
                    ram_wdata = enc_word(load_data);
                    ptr_d     = ptr_q + 1'b1;
                    // Last entry ends the load too: the pointer never wraps.
                    if (load_last || ptr_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        ptr_d   = '0;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .WIDTH  (RAM_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .re     (ram_re),
        .raddr  (fetch_addr[ADDR_W+1:2]),
        .rdata  (ram_rdata)
    );

    // The read register only changes on a RUN fetch, so gating it with sel_q
    // keeps instr (and parity_err) stable across stalls.
`ifdef IMEM_PARITY_EN
    assign parity_err = sel_q && (^ram_rdata);
    assign rd_ok      = sel_q && !(^ram_rdata);
`else
    assign rd_ok      = sel_q;
`endif

    assign instr       = rd_ok ? ram_rdata[DATA_W-1:0] : NOP_WORD;
    assign instr_valid = valid_q;
    assign addr_fault  = fault_q;
    assign load_ready  = (state_q == ST_LOAD);
    assign load_done   = done_q;

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic        load_start, load_valid, load_last, stall;
    logic [31:0] load_data, fetch_addr;
    logic        load_ready, load_done, instr_valid, addr_fault;
    logic [31:0] instr;
`ifdef IMEM_PARITY_EN
    logic        parity_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: word array plus expected output registers.
    logic [31:0] model_mem [DEPTH];

    imem_loadable u_dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .fetch_addr  (fetch_addr),
        .stall       (stall),
        .instr       (instr),
        .instr_valid (instr_valid),
`ifdef IMEM_PARITY_EN
        .parity_err  (parity_err),
`endif
        .addr_fault  (addr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_fault(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] m_instr(input logic [31:0] a);
        return m_fault(a) ? 32'h0 : model_mem[a / 4];
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 255) * 4;
            1:       return $urandom_range(0, 1023);
            2:       return $urandom();
            default: return $urandom_range(0, 255) * 4;
        endcase
    endfunction

    task automatic fetch_cycle(input logic [31:0] a);
        fetch_addr = a;
        stall      = 1'b0;
        tick();
    endtask

    task automatic begin_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_enter ready=%b valid=%b want ready=1 valid=0", load_ready, instr_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0;
        load_data = 0; fetch_addr = 0; stall = 0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 0 || addr_fault !== 0 ||
            load_ready !== 0 || load_done !== 0) begin
            errors++;
            $display("FAIL reset_vals instr=%h v=%b f=%b r=%b d=%b want all zero",
                     instr, instr_valid, addr_fault, load_ready, load_done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            load_start = (i == 10);
            stall      = (i == 20);
            tick();
            checks++;
            if (instr_valid !== (i == DEPTH - 1) || load_ready !== 1'b0 || instr !== 32'h0) begin
                errors++;
                $display("FAIL clear_cycle%0d valid=%b ready=%b instr=%h want valid=%b ready=0 instr=0",
                         i, instr_valid, load_ready, instr, (i == DEPTH - 1));
            end
        end
        load_start = 0; stall = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = (i == 0) ? 32'h0 : (i == 1) ? 32'h3FC : $urandom_range(0, 255) * 4;
            fetch_cycle(a);
            checks++;
            if (instr !== 32'h0 || instr_valid !== 1'b1 || addr_fault !== 1'b0) begin
                errors++;
                $display("FAIL clear_read a=%h instr=%h v=%b f=%b want 0/1/0", a, instr, instr_valid, addr_fault);
            end
        end
    endtask

    task automatic test_load_fetch();
        logic [31:0] w [3];
        w[0] = 32'h2004007D; w[1] = 32'h20050028; w[2] = 32'h0800000E;
        fetch_addr = 32'h4;
        begin_load();
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                load_valid = 0; tick();
            end
            load_valid = 1; load_data = w[i]; load_last = (i == 2);
            tick();
            model_mem[i] = w[i];
            checks++;
            if (load_done !== (i == 2) || load_ready !== (i != 2)) begin
                errors++;
                $display("FAIL load_word%0d done=%b ready=%b want done=%b ready=%b",
                         i, load_done, load_ready, (i == 2), (i != 2));
            end
        end
        load_valid = 0; load_last = 0;
        fetch_cycle(32'h0);
        checks++;
        if (load_done !== 1'b0 || instr !== 32'h2004007D || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse done=%b instr=%h want done=0 instr=2004007d", load_done, instr);
        end
        for (int i = 1; i < 4; i++) begin
            fetch_cycle(32'(i * 4));
            checks++;
            if (instr !== m_instr(32'(i * 4)) || addr_fault !== 1'b0) begin
                errors++;
                $display("FAIL fetch_%0h instr=%h want %h", i * 4, instr, m_instr(32'(i * 4)));
            end
        end
    endtask

    task automatic test_stall();
        fetch_cycle(32'h4);
        stall = 1'b1;
        fetch_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr !== 32'h20050028 || instr_valid !== 1'b1 || addr_fault !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d instr=%h want 20050028", i, instr);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (instr !== 32'h0800000E) begin
            errors++;
            $display("FAIL stall_release instr=%h want 0800000e", instr);
        end
    endtask

    task automatic test_faults();
        logic [31:0] al [4];
        al[0] = 32'h6; al[1] = 32'h400; al[2] = 32'h8000_0000; al[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            fetch_cycle(al[i]);
            checks++;
            if (addr_fault !== m_fault(al[i]) || instr !== m_instr(al[i]) || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL fault_%h fault=%b instr=%h want fault=%b instr=%h",
                         al[i], addr_fault, instr, m_fault(al[i]), m_instr(al[i]));
            end
        end
    endtask

    // Random load with ignored load_start/stall, then random fetch+stall run.
    task automatic test_random();
        int n;
        logic [31:0] e_instr;
        logic        e_fault;
        n = $urandom_range(4, 40);
        begin_load();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_valid = 0; tick();
            end
            load_start = ($urandom_range(0, 3) == 0);
            stall      = $urandom_range(0, 1);
            load_valid = 1; load_data = $urandom(); load_last = (i == n - 1);
            tick();
            model_mem[i] = load_data;
        end
        load_valid = 0; load_last = 0; load_start = 0;
        checks++;
        if (load_done !== 1'b1 || instr_valid !== 1'b1 || instr !== 32'h0) begin
            errors++;
            $display("FAIL rand_done done=%b v=%b instr=%h want 1/1/0", load_done, instr_valid, instr);
        end
        e_instr = 32'h0; e_fault = 1'b0;
        for (int i = 0; i < 60; i++) begin
            fetch_addr = rand_addr();
            stall      = ($urandom_range(0, 3) == 0);
            if (!stall) begin
                e_instr = m_instr(fetch_addr);
                e_fault = m_fault(fetch_addr);
            end
            tick();
            checks++;
            if (instr !== e_instr || addr_fault !== e_fault || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_fetch%0d a=%h instr=%h f=%b want %h f=%b",
                         i, fetch_addr, instr, addr_fault, e_instr, e_fault);
            end
        end
        stall = 0;
    endtask

    task automatic test_overflow();
        begin_load();
        for (int k = 0; k < 300; k++) begin
            load_valid = 1; load_last = 0; load_data = $urandom();
            stall = k[0];
            tick();
            if (k < DEPTH) model_mem[k] = load_data;
            checks++;
            if (load_done !== (k == DEPTH - 1) || load_ready !== (k < DEPTH - 1)) begin
                errors++;
                $display("FAIL ovf_word%0d done=%b ready=%b want done=%b ready=%b",
                         k, load_done, load_ready, (k == DEPTH - 1), (k < DEPTH - 1));
            end
        end
        load_valid = 0; stall = 0;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = (i == 0) ? 32'h0 : (i == 1) ? 32'h3FC : rand_addr();
            fetch_cycle(a);
            checks++;
            if (instr !== m_instr(a) || addr_fault !== m_fault(a)) begin
                errors++;
                $display("FAIL ovf_fetch a=%h instr=%h want %h", a, instr, m_instr(a));
            end
        end
    endtask

    task automatic test_reset_midload();
        begin_load();
        for (int i = 0; i < 2; i++) begin
            load_valid = 1; load_data = 32'hDEAD_0000 + i; load_last = 0;
            tick();
        end
        load_valid = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (load_ready !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset ready=%b v=%b want 0/0", load_ready, instr_valid);
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        for (int i = 0; i < DEPTH; i++) tick();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL midload_clear_end v=%b want 1", instr_valid);
        end
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a;
            a = (i < 2) ? 32'(i * 4) : $urandom_range(0, 255) * 4;
            fetch_cycle(a);
            checks++;
            if (instr !== 32'h0) begin
                errors++;
                $display("FAIL midload_read a=%h instr=%h want 0", a, instr);
            end
        end
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        fetch_cycle(32'h10);
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean perr=%b want 0", parity_err);
        end
        u_dut.u_ram.mem[3] = u_dut.u_ram.mem[3] ^ 33'h1_0000_0000;
        fetch_cycle(32'hC);
        checks++;
        if (parity_err !== 1'b1 || instr !== 32'h0) begin
            errors++;
            $display("FAIL parity_flip perr=%b instr=%h want 1/0", parity_err, instr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clear();
        test_load_fetch();
        test_stall();
        test_faults();
        test_random();
        test_overflow();
        test_reset_midload();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
